// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helpers for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must hold 0..WIDTH-1 and is never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder_v.sv
// rtl/full_adder_v.sv - single-bit full adder slice used by the serial adder
module full_adder_v (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_v.sv
// rtl/serial_adder_v.sv - LSB-first bit-serial adder with valid/ready handshakes (option: SERIAL_ADDER_OVERFLOW_EN)
module serial_adder_v
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             carry_res_q;
    logic [CW-1:0]    count_q;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             msb_cin_q;
`endif

    full_adder_v u_slice (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (count_q == LAST);
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the bottom.
    assign sum_next = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_res_q <= 1'b0;
            count_q     <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            msb_cin_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_sr    <= i_a;
                        b_sr    <= i_b;
                        carry_q <= i_carry;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_next;
                    carry_q <= fa_cout;
                    if (last_bit) begin
                        // Result registers stay put until the next operation finishes.
                        sum_q       <= sum_next;
                        carry_res_q <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        msb_cin_q   <= carry_q;
`endif
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sum   = sum_q;
    assign o_carry = carry_res_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign o_overflow = msb_cin_q ^ carry_res_q;
`endif

endmodule

// File: tb/tb_serial_adder_v.sv
// tb/tb_serial_adder_v.sv - scoreboard bench for serial_adder_v at WIDTH=8 and WIDTH=1 (option: SERIAL_ADDER_OVERFLOW_EN)
module tb_serial_adder_v;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, v8, r8, c8, rdy8, ov8, co8;
    logic [7:0] a8, b8, s8;
    logic       rst1, v1, r1, c1, rdy1, ov1, co1;
    logic [0:0] a1, b1, s1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic       of8, of1;
`endif

    serial_adder_v #(.WIDTH(8)) u_dut8 (
        .i_clk   (clk),
        .i_rst   (rst8),
        .i_valid (v8),
        .o_ready (rdy8),
        .i_a     (a8),
        .i_b     (b8),
        .i_carry (c8),
        .o_valid (ov8),
        .i_ready (r8),
        .o_sum   (s8),
        .o_carry (co8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .o_overflow (of8)
`endif
    );

    serial_adder_v #(.WIDTH(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst   (rst1),
        .i_valid (v1),
        .o_ready (rdy1),
        .i_a     (a1),
        .i_b     (b1),
        .i_carry (c1),
        .o_valid (ov1),
        .i_ready (r1),
        .o_sum   (s1),
        .o_carry (co1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .o_overflow (of1)
`endif
    );

    int         total = 0;
    int         bad   = 0;
    logic [9:0] q8[$];
    logic [2:0] q1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Packed {overflow, carry, sum}; overflow = carry into MSB xor carry out.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return {a[7] ^ b[7] ^ t[7] ^ t[8], t[8], t[7:0]};
    endfunction

    function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
        logic [1:0] t;
        t = {1'b0, a} + {1'b0, b} + {1'b0, c};
        return {a ^ b ^ t[0] ^ t[1], t[1], t[0]};
    endfunction

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
        int         n;
        logic [9:0] e;
        n = 0;
        while (!rdy8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_ready8", rdy8, 1);
        r8 = (hold == 0);
        a8 = a; b8 = b; c8 = c; v8 = 1'b1;
        q8.push_back(model8(a, b, c));
        @(negedge clk);
        n = 0;
        while (!ov8 && n < 20) begin
            check("busy_ready8", rdy8, 0);
            v8 = n[0];
            a8 = 8'hA5 ^ 8'(n);
            b8 = 8'h5A;
            @(negedge clk);
            n++;
        end
        check("latency8", n, 8);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid8", ov8, 1);
            check("hold_sum8", s8, q8[0][7:0]);
            check("hold_ready8", rdy8, 0);
            v8 = 1'b1;
            @(negedge clk);
        end
        r8 = 1'b1;
        v8 = 1'b1;
        e = q8.pop_front();
        check("valid8", ov8, 1);
        check("sum8", s8, e[7:0]);
        check("carry8", co8, e[8]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("ovf8", of8, e[9]);
`endif
        @(negedge clk);
        v8 = 1'b0;
        check("post_valid8", ov8, 0);
        check("post_ready8", rdy8, 1);
    endtask

    task automatic do_op1(input logic a, input logic b, input logic c);
        int         n;
        logic [2:0] e;
        check("idle_ready1", rdy1, 1);
        r1 = 1'b1;
        a1 = a; b1 = b; c1 = c; v1 = 1'b1;
        q1.push_back(model1(a, b, c));
        @(negedge clk);
        v1 = 1'b0;
        n = 0;
        while (!ov1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency1", n, 1);
        e = q1.pop_front();
        check("sum1", s1, e[0]);
        check("carry1", co1, e[1]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("ovf1", of1, e[2]);
`endif
        @(negedge clk);
        check("post_valid1", ov1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst8 = 1'b1; v8 = 1'b0; r8 = 1'b1; c8 = 1'b0; a8 = '0; b8 = '0;
        rst1 = 1'b1; v1 = 1'b0; r1 = 1'b1; c1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready8", rdy8, 1);
        check("rst_valid8", ov8, 0);
        check("rst_sum8", s8, 0);
        check("rst_carry8", co8, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("rst_ovf8", of8, 0);
`endif
        check("rst_ready1", rdy1, 1);
        rst8 = 1'b0;
        rst1 = 1'b0;

        do_op8(8'h3C, 8'h0F, 1'b0, 0);
        do_op8(8'hFF, 8'h01, 1'b0, 0);
        do_op8(8'hFF, 8'hFF, 1'b1, 0);
        do_op8(8'h12, 8'h34, 1'b0, 5);

        // Reset after three shift edges discards the operation.
        a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b1; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("midrst_ready8", rdy8, 1);
        check("midrst_valid8", ov8, 0);
        check("midrst_sum8", s8, 0);
        for (int i = 0; i < 12; i++) begin
            check("midrst_novalid8", ov8, 0);
            @(negedge clk);
        end
        do_op8(8'h01, 8'h01, 1'b0, 0);

        // Reset wins over a simultaneous accept.
        rst8 = 1'b1; v8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        rst8 = 1'b0; v8 = 1'b0;
        check("rstvalid_ready8", rdy8, 1);
        repeat (10) @(negedge clk);
        check("rstvalid_novalid8", ov8, 0);

        do_op8(8'h7F, 8'h01, 1'b0, 0);
        do_op8(8'h80, 8'h80, 1'b0, 0);
        do_op8(8'h10, 8'h20, 1'b0, 2);
        for (int i = 0; i < 4; i++) begin
            do_op8(8'($urandom), 8'($urandom), 1'($urandom), i % 2);
        end

        do_op1(1'b1, 1'b1, 1'b1);
        do_op1(1'b0, 1'b1, 1'b0);
        do_op1(1'b1, 1'b0, 1'b1);

        check("q8_empty", q8.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
